// File: rtl/alu_pkg.sv
// Shared types and widths for the ALU operation sequencer and its command FIFO.
package alu_pkg;
    localparam int OPW  = 2;
    localparam int SELW = 2;
    localparam int ZW   = 4;

    typedef struct packed {
        logic [SELW-1:0] select;
        logic [OPW-1:0]  b;
        logic [OPW-1:0]  a;
    } alu_cmd_t;

    localparam int CMDW = $bits(alu_cmd_t);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESULT = 2'd2
    } seq_state_t;

    // Counter width able to hold n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/alu_op_sequencer_if.sv
// Command-in and result-out handshakes of the sequencer; master is the producer/consumer side.
interface alu_op_sequencer_if;
    import alu_pkg::*;

    logic            cmd_valid;
    logic            cmd_ready;
    logic [OPW-1:0]  cmd_a;
    logic [OPW-1:0]  cmd_b;
    logic [SELW-1:0] cmd_select;
    logic            res_valid;
    logic            res_ready;
    logic [ZW-1:0]   res_z;
    logic [SELW-1:0] res_select;

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_select, res_ready,
        input  cmd_ready, res_valid, res_z, res_select
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_select, res_ready,
        output cmd_ready, res_valid, res_z, res_select
    );
endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; head entry is read combinationally from the read pointer.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     push,
    input  alu_cmd_t wdata,
    input  logic     pop,
    output alu_cmd_t rdata,
    output logic     full,
    output logic     empty
);
    localparam int AW = $clog2(DEPTH);

    alu_cmd_t      mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
endmodule

// File: rtl/alu_op_sequencer.sv
// Feeds buffered commands to an external combinational ALU one at a time, samples z after
// SETTLE cycles and hands the result out over a valid/ready handshake.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic                clk,
    input  logic                reset,
    alu_op_sequencer_if.slave   bus,
    output logic [OPW-1:0]      alu_a,
    output logic [OPW-1:0]      alu_b,
    output logic [SELW-1:0]     alu_select,
    input  logic [ZW-1:0]       alu_z,
    output logic [7:0]          op_count,
    output logic                busy
);
    localparam int CW = cnt_width(SETTLE);

    seq_state_t      state_q, state_d;
    alu_cmd_t        op_q, op_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            res_valid_q, res_valid_d;
    logic [ZW-1:0]   res_z_q, res_z_d;
    logic [SELW-1:0] res_sel_q, res_sel_d;
    logic [7:0]      op_count_q, op_count_d;

    logic     push, pop, full, empty;
    alu_cmd_t head, wdata;

    assign bus.cmd_ready = !full && !reset;
    assign push          = bus.cmd_valid && bus.cmd_ready;
    assign wdata         = {bus.cmd_select, bus.cmd_b, bus.cmd_a};

    alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (wdata),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        res_valid_d = res_valid_q;
        res_z_d     = res_z_q;
        res_sel_d   = res_sel_q;
        op_count_d  = op_count_q;
        pop         = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    op_d    = head;
                    cnt_d   = CW'(SETTLE - 1);
                    state_d = alu_pkg::SETTLE;
                end
            end
            alu_pkg::SETTLE: begin
                if (cnt_q == '0) begin
                    res_z_d     = alu_z;
                    res_sel_d   = op_q.select;
                    res_valid_d = 1'b1;
                    state_d     = RESULT;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESULT: begin
                // Handshake edge may immediately start the next command.
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    op_count_d  = op_count_q + 8'd1;
                    if (!empty) begin
                        pop     = 1'b1;
                        op_d    = head;
                        cnt_d   = CW'(SETTLE - 1);
                        state_d = alu_pkg::SETTLE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= '0;
            cnt_q       <= '0;
            res_valid_q <= 1'b0;
            res_z_q     <= '0;
            res_sel_q   <= '0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            res_valid_q <= res_valid_d;
            res_z_q     <= res_z_d;
            res_sel_q   <= res_sel_d;
            op_count_q  <= op_count_d;
        end
    end

    assign alu_a          = op_q.a;
    assign alu_b          = op_q.b;
    assign alu_select     = op_q.select;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_z      = res_z_q;
    assign bus.res_select = res_sel_q;
    assign op_count       = op_count_q;
    assign busy           = (state_q != IDLE) || !empty;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Drives two sequencers (SETTLE=1 and SETTLE=2) with shared stimulus and checks both
// every cycle against a queue-based model, plus hand-computed expectations.
module tb_alu_op_sequencer;
    localparam int DEPTH = 4;
    localparam int NI    = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] cv  = 2'b00;
    logic [1:0] ca  = '0, cb = '0, cs = '0;
    logic       rr  = 1'b0;

    logic       cmd_ready_w [NI];
    logic       res_valid_w [NI];
    logic [3:0] res_z_w     [NI];
    logic [1:0] res_sel_w   [NI];
    logic [1:0] alu_a_w     [NI];
    logic [1:0] alu_b_w     [NI];
    logic [1:0] alu_sel_w   [NI];
    logic [3:0] alu_z_w     [NI];
    logic [7:0] op_count_w  [NI];
    logic       busy_w      [NI];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Stand-in for the external combinational ALU.
    function automatic logic [3:0] alu_fn(input logic [1:0] s, input logic [1:0] a, input logic [1:0] b);
        case (s)
            2'd0:    return {2'b00, a} + {2'b00, b};
            2'd1:    return {2'b00, a} - {2'b00, b};
            2'd2:    return {a, b} ^ 4'h7;
            default: return {a & b, a | b};
        endcase
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NI; gi++) begin : g_dut
            alu_op_sequencer_if bus ();
            assign bus.cmd_valid  = cv[gi];
            assign bus.cmd_a      = ca;
            assign bus.cmd_b      = cb;
            assign bus.cmd_select = cs;
            assign bus.res_ready  = rr;
            assign cmd_ready_w[gi] = bus.cmd_ready;
            assign res_valid_w[gi] = bus.res_valid;
            assign res_z_w[gi]     = bus.res_z;
            assign res_sel_w[gi]   = bus.res_select;
            assign alu_z_w[gi]     = alu_fn(alu_sel_w[gi], alu_a_w[gi], alu_b_w[gi]);

            alu_op_sequencer #(.DEPTH(DEPTH), .SETTLE(gi + 1)) u_dut (
                .clk        (clk),
                .reset      (rst),
                .bus        (bus.slave),
                .alu_a      (alu_a_w[gi]),
                .alu_b      (alu_b_w[gi]),
                .alu_select (alu_sel_w[gi]),
                .alu_z      (alu_z_w[gi]),
                .op_count   (op_count_w[gi]),
                .busy       (busy_w[gi])
            );
        end
    endgenerate

    // ---------------- behavioural model ----------------
    logic [5:0] mq [NI][$];
    logic [1:0] m_a [NI], m_b [NI], m_s [NI];
    bit         m_wait [NI];
    int         m_cap  [NI];
    bit         m_rv   [NI];
    logic [3:0] m_rz   [NI];
    logic [1:0] m_rs   [NI];
    logic [7:0] m_cnt  [NI];
    int         m_done [NI];
    int         m_push [NI];
    int         cyc = 0;

    task automatic model_edge();
        for (int i = 0; i < NI; i++) begin
            if (rst) begin
                mq[i].delete();
                m_a[i] = 0; m_b[i] = 0; m_s[i] = 0;
                m_wait[i] = 0; m_cap[i] = 0;
                m_rv[i] = 0; m_rz[i] = 0; m_rs[i] = 0;
                m_cnt[i] = 0; m_done[i] = 0; m_push[i] = 0;
            end else begin
                int sz;
                bit pu, po, hs;
                logic [5:0] c;
                sz = mq[i].size();
                pu = cv[i] && (sz < DEPTH);
                hs = m_rv[i] && rr;
                po = (sz > 0) && ((!m_wait[i] && !m_rv[i]) || hs);
                if (hs) begin
                    m_rv[i] = 0;
                    m_cnt[i] = m_cnt[i] + 8'd1;
                    m_done[i]++;
                    $display("inst%0d result %0d: sel=%0d z=%h", i, m_done[i], m_rs[i], m_rz[i]);
                end
                if (m_wait[i] && cyc == m_cap[i]) begin
                    m_rz[i] = alu_fn(m_s[i], m_a[i], m_b[i]);
                    m_rs[i] = m_s[i];
                    m_rv[i] = 1;
                    m_wait[i] = 0;
                end
                if (po) begin
                    c = mq[i].pop_front();
                    m_a[i] = c[1:0]; m_b[i] = c[3:2]; m_s[i] = c[5:4];
                    m_wait[i] = 1;
                    m_cap[i] = cyc + i + 1;
                end
                if (pu) begin
                    mq[i].push_back({cs, cb, ca});
                    m_push[i]++;
                end
            end
        end
        cyc++;
    endtask

    task automatic check(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s inst=%0d cyc=%0d got=%0h want=%0h", nm, i, cyc, act, exp);
        end
    endtask

    task automatic compare();
        for (int i = 0; i < NI; i++) begin
            check("cmd_ready",  i, cmd_ready_w[i], (!rst && mq[i].size() < DEPTH));
            check("alu_a",      i, alu_a_w[i],     m_a[i]);
            check("alu_b",      i, alu_b_w[i],     m_b[i]);
            check("alu_select", i, alu_sel_w[i],   m_s[i]);
            check("res_valid",  i, res_valid_w[i], m_rv[i]);
            check("res_z",      i, res_z_w[i],     m_rz[i]);
            check("res_select", i, res_sel_w[i],   m_rs[i]);
            check("op_count",   i, op_count_w[i],  m_cnt[i]);
            check("busy",       i, busy_w[i],      (m_wait[i] || m_rv[i] || mq[i].size() > 0));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic drain(input int budget);
        bit done;
        done = 0;
        for (int n = 0; n < budget && !done; n++) begin
            step();
            done = !busy_w[0] && !busy_w[1];
        end
        check("drain_timeout", 0, done, 1);
    endtask

    initial begin
        int acc [NI];
        int rise [NI][4];
        logic [1:0] tag [NI][4];
        int nr [NI];
        bit pv [NI];
        bit done;

        // Reset with cmd_valid asserted: nothing may be accepted.
        rst = 1; cv = 2'b11; ca = 2'd1; cb = 2'd1; cs = 2'd1;
        for (int k = 0; k < 2; k++) begin
            step();
            for (int i = 0; i < NI; i++) begin
                check("rst_cmd_ready", i, cmd_ready_w[i], 0);
                check("rst_busy",      i, busy_w[i],      0);
                check("rst_op_count",  i, op_count_w[i],  0);
            end
        end
        rst = 0; cv = 2'b00;
        #1;
        for (int i = 0; i < NI; i++) check("post_rst_ready", i, cmd_ready_w[i], 1);

        // Single op a=3 b=1 select=2.
        ca = 2'd3; cb = 2'd1; cs = 2'd2; cv = 2'b11;
        step();                                   // edge 0: push
        cv = 2'b00;
        step();                                   // edge 1: pop
        for (int i = 0; i < NI; i++) begin
            check("single_alu_a",   i, alu_a_w[i],   3);
            check("single_alu_b",   i, alu_b_w[i],   1);
            check("single_alu_sel", i, alu_sel_w[i], 2);
        end
        step();                                   // edge 2
        check("single_rv_s1",  0, res_valid_w[0], 1);
        check("single_z_s1",   0, res_z_w[0],     4'hA);
        check("single_sel_s1", 0, res_sel_w[0],   2);
        check("single_rv_s2",  1, res_valid_w[1], 0);
        rr = 1;
        step();                                   // edge 3
        check("single_cnt_s1", 0, op_count_w[0],  1);
        check("single_rv0_s1", 0, res_valid_w[0], 0);
        check("single_z_s2",   1, res_z_w[1],     4'hA);
        step();                                   // edge 4
        check("single_cnt_s2", 1, op_count_w[1],  1);
        rr = 0;

        // Backpressure: six back-to-back pushes, consumer stalled.
        acc = '{0, 0};
        for (int k = 0; k < 6; k++) begin
            cv = 2'b11;
            if (k == 0) begin ca = 2'd2; cb = 2'd3; cs = 2'd1; end
            else begin ca = 2'($urandom); cb = 2'($urandom); cs = 2'($urandom); end
            for (int i = 0; i < NI; i++) if (cmd_ready_w[i]) acc[i]++;
            step();
        end
        cv = 2'b00;
        for (int i = 0; i < NI; i++) begin
            check("bp_accepted",  i, acc[i],         5);
            check("bp_ready_low", i, cmd_ready_w[i], 0);
            check("bp_res_z",     i, res_z_w[i],     4'hF);
            check("bp_res_sel",   i, res_sel_w[i],   1);
        end
        rr = 1;
        drain(200);
        for (int i = 0; i < NI; i++) check("bp_op_count", i, op_count_w[i], 6);

        // Streaming: four commands, consumer always ready.
        nr = '{0, 0};
        for (int i = 0; i < NI; i++) pv[i] = res_valid_w[i];
        for (int n = 0; n < 20; n++) begin
            if (n < 4) begin
                cv = 2'b11; ca = 2'($urandom); cb = 2'($urandom); cs = 2'(n);
            end else begin
                cv = 2'b00;
            end
            step();
            for (int i = 0; i < NI; i++) begin
                if (res_valid_w[i] && !pv[i] && nr[i] < 4) begin
                    rise[i][nr[i]] = n;
                    tag[i][nr[i]]  = res_sel_w[i];
                    nr[i]++;
                end
                pv[i] = res_valid_w[i];
            end
        end
        for (int i = 0; i < NI; i++) begin
            check("stream_nres", i, nr[i], 4);
            for (int k = 0; k < 4; k++) begin
                if (k < nr[i]) begin
                    check("stream_edge", i, rise[i][k], (i + 2) * (k + 1));
                    check("stream_tag",  i, tag[i][k],  k);
                end
            end
        end
        drain(50);
        for (int i = 0; i < NI; i++) begin
            check("stream_busy",  i, busy_w[i],     0);
            check("stream_count", i, op_count_w[i], 10);
        end

        // Reset while settling with three commands buffered.
        rr = 0;
        for (int k = 0; k < 5; k++) begin
            cv = 2'b11; ca = 2'($urandom); cb = 2'($urandom); cs = 2'($urandom);
            step();
        end
        cv = 2'b00; rr = 1;
        step();
        for (int i = 0; i < NI; i++) begin
            check("midop_busy",  i, busy_w[i],      1);
            check("midop_rv",    i, res_valid_w[i], 0);
            check("midop_ready", i, cmd_ready_w[i], 1);
        end
        rr = 0; rst = 1;
        step();
        for (int i = 0; i < NI; i++) begin
            check("midrst_busy",  i, busy_w[i],     0);
            check("midrst_count", i, op_count_w[i], 0);
        end
        rst = 0; rr = 1;
        for (int k = 0; k < 10; k++) begin
            step();
            for (int i = 0; i < NI; i++) check("midrst_no_result", i, res_valid_w[i], 0);
        end
        ca = 2'd1; cb = 2'd2; cs = 2'd0; cv = 2'b11;
        step();
        cv = 2'b00;
        drain(50);
        for (int i = 0; i < NI; i++) begin
            check("fresh_count", i, op_count_w[i], 1);
            check("fresh_z",     i, res_z_w[i],    4'h3);
        end

        // Wrap: 257 random results per instance from a clean reset.
        rst = 1;
        step();
        rst = 0;
        done = 0;
        for (int n = 0; n < 20000 && !done; n++) begin
            for (int i = 0; i < NI; i++) cv[i] = (m_push[i] < 257) && ($urandom_range(0, 3) != 0);
            ca = 2'($urandom); cb = 2'($urandom); cs = 2'($urandom);
            rr = ($urandom_range(0, 3) != 0);
            step();
            done = (m_done[0] >= 257) && (m_done[1] >= 257);
        end
        cv = 2'b00;
        check("wrap_timeout", 0, done, 1);
        drain(50);
        for (int i = 0; i < NI; i++) begin
            check("wrap_count", i, op_count_w[i], 1);
            check("wrap_busy",  i, busy_w[i],     0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule
